// File: rtl/scan_pkg.sv
// Shared types and helpers for the polygon laser-scanner engine.
package scan_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SPINUP,
    ACQUIRE,
    PRE,
    EXPOSE,
    GAP,
    WINDOW
  } scan_state_e;

  // Lane that carries the photodiode sync beam.
  localparam int SYNC_LANE = 0;

  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/pd_sync.sv
// Two-flop synchronizer with a registered falling-edge pulse for asynchronous pins.
module pd_sync (
  input  logic clock,
  input  logic reset,
  input  logic pin,
  output logic fall
);

  logic s1, s2, s3;

  // Flops reset high so an idle-high pin never produces a spurious edge.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      s1   <= 1'b1;
      s2   <= 1'b1;
      s3   <= 1'b1;
      fall <= 1'b0;
    end else begin
      s1   <= pin;
      s2   <= s1;
      s3   <= s2;
      fall <= s3 & ~s2;
    end
  end

endmodule

// File: rtl/laserscan_engine.sv
// Polygon laser-scanner engine: motor clock, facet sync lock and per-facet
// exposure streaming to LANES laser outputs.
module laserscan_engine
  import scan_pkg::*;
#(
  parameter int POLY_HALF_PERIOD = 4000,
  parameter int FACETS           = 4,
  parameter int FACET_TICKS      = 200000,
  parameter int JITTER_TICKS     = 1000,
  parameter int SPINUP_TICKS     = 2000000,
  parameter int SYNC_START       = 2000,
  parameter int BITS_PER_LINE    = 8000,
  parameter int TICKS_PER_BIT    = 20,
  parameter int LANES            = 1
) (
  input  logic                                          clock,
  input  logic                                          reset,
  input  logic                                          start,
  input  logic                                          photodiodepin,
  output logic                                          polypin,
  output logic [LANES-1:0]                              laserpin,
  input  logic [LANES-1:0]                              s_data,
  input  logic                                          s_valid,
  output logic                                          s_ready,
  output logic [((FACETS > 1) ? $clog2(FACETS) : 1)-1:0] facet,
  output logic                                          line_done,
  output logic                                          err_sync,
  output logic                                          err_underrun,
  output scan_state_e                                   dbg_state
);

  localparam int FACET_W = (FACETS > 1) ? $clog2(FACETS) : 1;
  localparam int CNT_W   = cnt_width(SPINUP_TICKS, FACET_TICKS + JITTER_TICKS, BITS_PER_LINE);
  localparam int PH_W    = (POLY_HALF_PERIOD > 1) ? $clog2(POLY_HALF_PERIOD) : 1;
  localparam int TPB_W   = (TICKS_PER_BIT > 1) ? $clog2(TICKS_PER_BIT) : 1;

  localparam logic [CNT_W-1:0]   SPIN_LAST  = CNT_W'(SPINUP_TICKS - 1);
  localparam logic [CNT_W-1:0]   PRE_LAST   = CNT_W'(SYNC_START - 1);
  localparam logic [CNT_W-1:0]   BIT_LAST   = CNT_W'(BITS_PER_LINE - 1);
  localparam logic [CNT_W-1:0]   GAP_LAST   = CNT_W'(FACET_TICKS - JITTER_TICKS - 1);
  localparam logic [CNT_W-1:0]   WIN_LAST   = CNT_W'(FACET_TICKS + JITTER_TICKS - 1);
  localparam logic [PH_W-1:0]    PH_LAST    = PH_W'(POLY_HALF_PERIOD - 1);
  localparam logic [TPB_W-1:0]   TPB_LAST   = TPB_W'(TICKS_PER_BIT - 1);
  localparam logic [FACET_W-1:0] FACET_LAST = FACET_W'(FACETS - 1);
  localparam logic [LANES-1:0]   SYNC_MASK  = LANES'(1) << SYNC_LANE;

  if (SYNC_START + BITS_PER_LINE * TICKS_PER_BIT >= FACET_TICKS - JITTER_TICKS) begin : g_bad_timing
    $fatal(1, "laserscan_engine: exposure does not fit before the sync window opens");
  end

  scan_state_e        state, state_next;
  logic               hit;
  logic [CNT_W-1:0]   tmr;
  logic [CNT_W-1:0]   since;
  logic [CNT_W-1:0]   bcnt;
  logic [TPB_W-1:0]   tcnt;
  logic [PH_W-1:0]    pcnt;
  logic [LANES-1:0]   word_q;
  logic               enter_run;

  pd_sync u_pd_sync (
    .clock (clock),
    .reset (reset),
    .pin   (photodiodepin),
    .fall  (hit)
  );

  assign dbg_state = state;
  assign enter_run = (state == IDLE) && (state_next == SPINUP);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = SPINUP;
      SPINUP:  if (tmr == SPIN_LAST) state_next = ACQUIRE;
      ACQUIRE: begin
        if (hit)                    state_next = PRE;
        else if (tmr == SPIN_LAST)  state_next = SPINUP;
      end
      PRE:     if (tmr == PRE_LAST) state_next = EXPOSE;
      EXPOSE:  if (tcnt == TPB_LAST && bcnt == BIT_LAST) state_next = GAP;
      GAP:     if (since >= GAP_LAST) state_next = WINDOW;
      WINDOW: begin
        if (hit)                    state_next = PRE;
        else if (since >= WIN_LAST) state_next = ACQUIRE;
      end
      default: state_next = IDLE;
    endcase
    if (!start) state_next = IDLE;
  end

  // Stream handshake: a word transfers on a clock edge where s_valid && s_ready.
  // s_ready depends only on the engine timing, never on s_valid; a missing word
  // at a bit boundary is still consumed as a dark bit and flagged.
  always_comb begin
    s_ready  = 1'b0;
    laserpin = '0;
    case (state)
      ACQUIRE, WINDOW: laserpin = SYNC_MASK;
      PRE:             s_ready  = start && (tmr == PRE_LAST);
      EXPOSE: begin
        laserpin = word_q;
        s_ready  = start && (tcnt == TPB_LAST) && (bcnt != BIT_LAST);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      tmr   <= '0;
      since <= '0;
      facet <= '0;
    end else begin
      if (state_next != state) tmr <= '0;
      else if (tmr != '1)      tmr <= tmr + CNT_W'(1);
      // Saturating count so a lost polygon never wraps into a false window.
      if (state_next == PRE && state != PRE) since <= '0;
      else if (since != '1)                  since <= since + CNT_W'(1);
      if (state_next == PRE && state == ACQUIRE)     facet <= '0;
      else if (state_next == PRE && state == WINDOW) facet <= (facet == FACET_LAST) ? '0 : facet + FACET_W'(1);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      word_q <= '0;
      tcnt   <= '0;
      bcnt   <= '0;
    end else if (s_ready) begin
      word_q <= s_valid ? s_data : '0;
      tcnt   <= '0;
      bcnt   <= (state == PRE) ? '0 : bcnt + CNT_W'(1);
    end else if (state == EXPOSE) begin
      tcnt   <= tcnt + TPB_W'(1);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      line_done    <= 1'b0;
      err_sync     <= 1'b0;
      err_underrun <= 1'b0;
    end else begin
      line_done <= (state == EXPOSE) && (state_next == GAP);
      if (enter_run) begin
        err_sync     <= 1'b0;
        err_underrun <= 1'b0;
      end else begin
        if (s_ready && !s_valid) err_underrun <= 1'b1;
        if ((hit && state != ACQUIRE && state != WINDOW) ||
            (!hit && state == ACQUIRE && tmr == SPIN_LAST) ||
            (!hit && state == WINDOW && since >= WIN_LAST))
          err_sync <= 1'b1;
      end
    end
  end

  // Motor clock keeps its phase through every running state change.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pcnt    <= '0;
      polypin <= 1'b0;
    end else if (state_next == IDLE) begin
      pcnt    <= '0;
      polypin <= 1'b0;
    end else if (state != IDLE) begin
      if (pcnt == PH_LAST) begin
        pcnt    <= '0;
        polypin <= ~polypin;
      end else begin
        pcnt <= pcnt + PH_W'(1);
      end
    end
  end

endmodule
